mockingboard_psg_decoder: RTL and testbench

Passive Apple II bus decoder that turns the 6502's register traffic to a Mockingboard slot back into the AY-3-8913 commands it produces. It keeps a shadow copy of each VIA's port registers and tracks each PSG's bus-control state. From these it emits a buffered stream of PSG register-write and PSG-reset events. It snoops the same bus cycles as the Mockingboard card, never drives the bus, and feeds downstream consumers such as a logger, an external synth bridge or an audio-to-HDMI metadata path.

---
 rtl/mockingboard_psg_decoder_if.sv | 31 +++
 rtl/mockingboard_psg_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_mockingboard_psg_decoder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mockingboard_psg_decoder_if.sv
`default_nettype none
// ============================================================================
// Module  : mockingboard_psg_decoder_if
// Brief   : Snooped 6502 bus strobe and PSG event stream bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface mockingboard_psg_decoder_if;
  logic        phi1_posedge;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        rw_n;

  logic        evt_valid;
  logic        evt_ready;
  logic        evt_chip;
  logic        evt_reset;
  logic [3:0]  evt_reg;
  logic [7:0]  evt_data;
  logic        ovf_o;

  modport master (
    output phi1_posedge, addr, data, rw_n, evt_ready,
    input  evt_valid, evt_chip, evt_reset, evt_reg, evt_data, ovf_o
  );

  modport slave (
    input  phi1_posedge, addr, data, rw_n, evt_ready,
    output evt_valid, evt_chip, evt_reset, evt_reg, evt_data, ovf_o
  );
endinterface
`default_nettype wire

// File: rtl/mockingboard_psg_decoder.sv
`default_nettype none
// ============================================================================
// Module  : mockingboard_psg_decoder
// Brief   : Passive Mockingboard snooper; rebuilds AY-3-8913 writes/resets.
// Revision: 1.0 - initial release
// ============================================================================
module mockingboard_psg_decoder #(
  parameter int SLOT       = 4,
  parameter bit ENABLE     = 1'b1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk_logic,
  input  logic                       system_reset_n,
  mockingboard_psg_decoder_if.slave  bus
);

  localparam int          c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int          c_evt_w  = 14;
  localparam logic [3:0]  c_slot   = SLOT[3:0];
  localparam logic [c_ptr_w:0] c_ptr_one = 1;

  typedef enum logic [2:0] {
    CMD_INACTIVE = 3'd0,
    CMD_READ     = 3'd1,
    CMD_WRITE    = 3'd2,
    CMD_LATCH    = 3'd3,
    CMD_RESET    = 3'd4
  } cmd_t;

  function automatic logic [7:0] pins(input logic [7:0] out_reg, input logic [7:0] ddr);
    return (out_reg & ddr) | ~ddr;
  endfunction

  function automatic cmd_t decode(input logic [7:0] pb);
    cmd_t c;
    if (!pb[2]) begin
      c = CMD_RESET;
    end else begin
      case (pb[1:0])
        2'b11:   c = CMD_LATCH;
        2'b10:   c = CMD_WRITE;
        2'b01:   c = CMD_READ;
        default: c = CMD_INACTIVE;
      endcase
    end
    return c;
  endfunction

  // Shadow VIA registers and bus-control state, indexed by side (addr[7])
  logic [7:0] r_orb  [2];
  logic [7:0] r_ora  [2];
  logic [7:0] r_ddrb [2];
  logic [7:0] r_ddra [2];
  cmd_t       r_cmd  [2];
  logic [3:0] r_reg_q  [2];
  logic       r_reg_ok [2];

  logic [7:0] w_orb_nxt  [2];
  logic [7:0] w_ora_nxt  [2];
  logic [7:0] w_ddrb_nxt [2];
  logic [7:0] w_ddra_nxt [2];
  cmd_t       w_cmd_nxt  [2];
  logic [3:0] w_reg_q_nxt  [2];
  logic       w_reg_ok_nxt [2];

  logic               w_hit;
  logic               w_known;
  logic               w_side;
  logic [3:0]         w_regn;
  logic [7:0]         w_orb_n, w_ora_n, w_ddrb_n, w_ddra_n;
  logic [7:0]         w_pb_new, w_pa_new, w_pa_old;
  logic               w_pa_chg;
  cmd_t               w_cmd_old, w_cmd_new;
  logic               w_push;
  logic [c_evt_w-1:0] w_push_entry;
  logic               w_unused_addr;

  assign w_side        = bus.addr[7];
  assign w_regn        = bus.addr[3:0];
  assign w_unused_addr = &{1'b0, bus.addr[6:4]};
  assign w_hit         = bus.phi1_posedge & ~bus.rw_n & ENABLE
                       & (bus.addr[15:8] == {4'hC, c_slot});

  always_comb begin
    w_orb_nxt    = r_orb;
    w_ora_nxt    = r_ora;
    w_ddrb_nxt   = r_ddrb;
    w_ddra_nxt   = r_ddra;
    w_cmd_nxt    = r_cmd;
    w_reg_q_nxt  = r_reg_q;
    w_reg_ok_nxt = r_reg_ok;
    w_push       = 1'b0;
    w_push_entry = '0;
    w_known      = 1'b1;

    w_orb_n  = r_orb[w_side];
    w_ora_n  = r_ora[w_side];
    w_ddrb_n = r_ddrb[w_side];
    w_ddra_n = r_ddra[w_side];
    case (w_regn)
      4'd0:        w_orb_n  = bus.data;
      4'd1, 4'd15: w_ora_n  = bus.data;
      4'd2:        w_ddrb_n = bus.data;
      4'd3:        w_ddra_n = bus.data;
      default:     w_known  = 1'b0;
    endcase

    w_pb_new  = pins(w_orb_n, w_ddrb_n);
    w_pa_new  = pins(w_ora_n, w_ddra_n);
    w_pa_old  = pins(r_ora[w_side], r_ddra[w_side]);
    w_pa_chg  = (w_pa_new != w_pa_old);
    w_cmd_old = r_cmd[w_side];
    w_cmd_new = decode(w_pb_new);

    // Unmapped VIA registers leave every piece of state untouched
    if (w_hit && w_known) begin
      w_orb_nxt[w_side]  = w_orb_n;
      w_ora_nxt[w_side]  = w_ora_n;
      w_ddrb_nxt[w_side] = w_ddrb_n;
      w_ddra_nxt[w_side] = w_ddra_n;
      w_cmd_nxt[w_side]  = w_cmd_new;

      if (w_cmd_new == CMD_RESET && w_cmd_old != CMD_RESET) begin
        w_push               = 1'b1;
        w_push_entry         = {w_side, 1'b1, 4'd0, 8'd0};
        w_reg_q_nxt[w_side]  = 4'd0;
        w_reg_ok_nxt[w_side] = 1'b0;
      end else if (w_cmd_new == CMD_LATCH && (w_cmd_old != CMD_LATCH || w_pa_chg)) begin
        w_reg_q_nxt[w_side]  = w_pa_new[3:0];
        w_reg_ok_nxt[w_side] = (w_pa_new[7:4] == 4'd0);
      end else if (w_cmd_new == CMD_WRITE && r_reg_ok[w_side]
                   && (w_cmd_old != CMD_WRITE || w_pa_chg)) begin
        w_push       = 1'b1;
        w_push_entry = {w_side, 1'b0, r_reg_q[w_side], w_pa_new};
      end
    end
  end

  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      for (int s = 0; s < 2; s++) begin
        r_orb[s]    <= '0;
        r_ora[s]    <= '0;
        r_ddrb[s]   <= '0;
        r_ddra[s]   <= '0;
        r_cmd[s]    <= CMD_INACTIVE;
        r_reg_q[s]  <= '0;
        r_reg_ok[s] <= 1'b0;
      end
    end else begin
      r_orb    <= w_orb_nxt;
      r_ora    <= w_ora_nxt;
      r_ddrb   <= w_ddrb_nxt;
      r_ddra   <= w_ddra_nxt;
      r_cmd    <= w_cmd_nxt;
      r_reg_q  <= w_reg_q_nxt;
      r_reg_ok <= w_reg_ok_nxt;
    end
  end

  // Event FIFO: pointers carry an extra wrap bit to tell full from empty
  logic [c_evt_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w:0]   r_wr_ptr, r_rd_ptr;
  logic               r_ovf;
  logic               w_empty, w_full, w_pop, w_push_ok, w_drop;
  logic [c_evt_w-1:0] w_head;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w])
                   && (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
  assign w_pop     = ~w_empty & bus.evt_ready;
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + c_ptr_one;
      if (w_drop)    r_ovf    <= 1'b1;
    end
  end

  always_ff @(posedge clk_logic) begin
    if (w_push_ok) r_mem[r_wr_ptr[c_ptr_w-1:0]] <= w_push_entry;
  end

  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr[c_ptr_w-1:0]];

  assign bus.evt_valid = ~w_empty;
  assign bus.evt_chip  = w_head[13];
  assign bus.evt_reset = w_head[12];
  assign bus.evt_reg   = w_head[11:8];
  assign bus.evt_data  = w_head[7:0];
  assign bus.ovf_o     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mockingboard_psg_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_mockingboard_psg_decoder
// Brief   : Directed + random bench against a behavioural Mockingboard model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mockingboard_psg_decoder;

  localparam int DEPTH = 8;
  localparam int K_INACTIVE = 0, K_READ = 1, K_WRITE = 2, K_LATCH = 3, K_RESET = 4;

  logic clk_logic = 1'b0;
  logic system_reset_n;
  always #5 clk_logic = ~clk_logic;

  mockingboard_psg_decoder_if bus ();

  mockingboard_psg_decoder #(.SLOT(4), .ENABLE(1'b1), .FIFO_DEPTH(DEPTH)) dut (
    .clk_logic      (clk_logic),
    .system_reset_n (system_reset_n),
    .bus            (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: VIA shadows, PSG bus state, and the expected event queue
  logic [7:0]  m_orb [2], m_ora [2], m_ddrb [2], m_ddra [2];
  int          m_cmd [2];
  logic [3:0]  m_regq [2];
  bit          m_ok [2];
  bit          m_ovf;
  logic [13:0] exp_q [$];

  function automatic logic [7:0] pin_val(logic [7:0] o, logic [7:0] d);
    logic [7:0] p;
    for (int b = 0; b < 8; b++) p[b] = d[b] ? o[b] : 1'b1;
    return p;
  endfunction

  function automatic int pb_cmd(logic [7:0] pb);
    if (pb[2] == 1'b0) return K_RESET;
    if (pb[1:0] == 2'b11) return K_LATCH;
    if (pb[1:0] == 2'b10) return K_WRITE;
    if (pb[1:0] == 2'b01) return K_READ;
    return K_INACTIVE;
  endfunction

  function automatic logic [13:0] head();
    return {bus.evt_chip, bus.evt_reset, bus.evt_reg, bus.evt_data};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_orb[s] = 0; m_ora[s] = 0; m_ddrb[s] = 0; m_ddra[s] = 0;
      m_cmd[s] = K_INACTIVE; m_regq[s] = 0; m_ok[s] = 0;
    end
    m_ovf = 0;
    exp_q.delete();
  endtask

  task automatic model_push(logic [13:0] e);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else m_ovf = 1;
  endtask

  task automatic model_write(logic side, logic [3:0] rn, logic [7:0] d);
    int s, c_old, c_new;
    logic [7:0] pa_old, pa_new;
    s = side ? 1 : 0;
    if (!(rn inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd15})) return;
    pa_old = pin_val(m_ora[s], m_ddra[s]);
    if (rn == 0) m_orb[s] = d;
    else if (rn == 2) m_ddrb[s] = d;
    else if (rn == 3) m_ddra[s] = d;
    else m_ora[s] = d;
    pa_new = pin_val(m_ora[s], m_ddra[s]);
    c_new = pb_cmd(pin_val(m_orb[s], m_ddrb[s]));
    c_old = m_cmd[s];
    if (c_new == K_RESET && c_old != K_RESET) begin
      model_push({side, 1'b1, 4'h0, 8'h00});
      m_regq[s] = 0; m_ok[s] = 0;
    end else if (c_new == K_LATCH && (c_old != K_LATCH || pa_new != pa_old)) begin
      m_regq[s] = pa_new[3:0];
      m_ok[s] = (pa_new < 8'd16);
    end else if (c_new == K_WRITE && m_ok[s] && (c_old != K_WRITE || pa_new != pa_old)) begin
      model_push({side, 1'b0, m_regq[s], pa_new});
    end
    m_cmd[s] = c_new;
  endtask

  task automatic check_outputs();
    check("valid", {31'd0, bus.evt_valid}, {31'd0, exp_q.size() > 0});
    check("ovf", {31'd0, bus.ovf_o}, {31'd0, m_ovf});
    if (exp_q.size() > 0) check("head", {18'd0, head()}, {18'd0, exp_q[0]});
    else check("idle_fields", {18'd0, head()}, 32'd0);
  endtask

  // One clock: drive at negedge, model at posedge, check at the next negedge
  task automatic cycle(bit strobe, logic [15:0] a, logic [7:0] d, bit rw);
    bit pop;
    bus.phi1_posedge = strobe; bus.addr = a; bus.data = d; bus.rw_n = rw;
    pop = bus.evt_ready && (exp_q.size() > 0);
    @(posedge clk_logic);
    if (pop) void'(exp_q.pop_front());
    if (strobe && !rw && a[15:8] == 8'hC4) model_write(a[7], a[3:0], d);
    @(negedge clk_logic);
    bus.phi1_posedge = 0;
    check_outputs();
  endtask

  task automatic wr(logic side, logic [3:0] rn, logic [7:0] d);
    logic [2:0] junk;
    junk = 3'($urandom_range(0, 7));
    cycle(1'b1, {8'hC4, side, junk, rn}, d, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0000, 8'h00, 1'b1);
  endtask

  task automatic drain();
    bus.evt_ready = 1;
    for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) idle();
    bus.evt_ready = 0;
    check("drained", {31'd0, bus.evt_valid}, 32'd0);
  endtask

  task automatic do_reset();
    bus.phi1_posedge = 0;
    system_reset_n = 0;
    @(posedge clk_logic);
    model_reset();
    @(negedge clk_logic);
    system_reset_n = 1;
    check_outputs();
  endtask

  task automatic latch_write(logic side);
    wr(side, 4'd1, 8'h07); wr(side, 4'd0, 8'h07); wr(side, 4'd0, 8'h04);
    wr(side, 4'd1, 8'h38); wr(side, 4'd0, 8'h06);
  endtask

  task automatic init_side(logic side);
    wr(side, 4'd2, 8'hFF); wr(side, 4'd3, 8'hFF); wr(side, 4'd0, 8'h00); wr(side, 4'd0, 8'h04);
  endtask

  initial begin
    logic [7:0] orb_tab [6];
    logic [3:0] reg_tab [10];
    orb_tab = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h03, 8'h00};
    reg_tab = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd15, 4'd2, 4'd3, 4'd5, 4'd9};
    bus.phi1_posedge = 0; bus.addr = 0; bus.data = 0; bus.rw_n = 1; bus.evt_ready = 0;
    system_reset_n = 0;
    model_reset();
    @(negedge clk_logic);
    do_reset();

    // Left PSG init: one reset event
    init_side(1'b0);
    check("init_reset_evt", {18'd0, head()}, {18'd0, 1'b0, 1'b1, 4'h0, 8'h00});
    check("init_ovf", {31'd0, bus.ovf_o}, 32'd0);
    drain();

    latch_write(1'b0);
    wr(1'b0, 4'd0, 8'h04);
    check("left_write_evt", {18'd0, head()}, {18'd0, 1'b0, 1'b0, 4'h7, 8'h38});
    drain();

    // Right PSG, including a pa change while WRITE is held
    init_side(1'b1);
    check("right_reset_evt", {18'd0, head()}, {18'd0, 1'b1, 1'b1, 4'h0, 8'h00});
    drain();
    latch_write(1'b1);
    wr(1'b1, 4'd1, 8'h3F);
    wr(1'b1, 4'd0, 8'h04);
    check("right_write_evt", {18'd0, head()}, {18'd0, 1'b1, 1'b0, 4'h7, 8'h38});
    bus.evt_ready = 1; idle(); bus.evt_ready = 0;
    check("right_update_evt", {18'd0, head()}, {18'd0, 1'b1, 1'b0, 4'h7, 8'h3F});
    drain();

    // Out-of-range latch, reads and foreign addresses all stay silent
    wr(1'b0, 4'd1, 8'h17); wr(1'b0, 4'd0, 8'h07); wr(1'b0, 4'd0, 8'h04); wr(1'b0, 4'd0, 8'h06);
    wr(1'b0, 4'd0, 8'h04);
    cycle(1'b1, 16'hC400, 8'h00, 1'b1);
    cycle(1'b1, 16'hC500, 8'h00, 1'b0);
    cycle(1'b1, 16'hC300, 8'h00, 1'b0);
    cycle(1'b1, 16'hC3FF, 8'h00, 1'b0);
    check("silent_valid", {31'd0, bus.evt_valid}, 32'd0);

    // Fill, pop+push while full, then overflow
    wr(1'b0, 4'd1, 8'h05); wr(1'b0, 4'd0, 8'h07); wr(1'b0, 4'd0, 8'h06);
    for (int i = 0; i < DEPTH - 1; i++) wr(1'b0, 4'd1, 8'(8'h10 + i));
    check("full_no_ovf", {31'd0, bus.ovf_o}, 32'd0);
    bus.evt_ready = 1;
    wr(1'b0, 4'd1, 8'h40);
    bus.evt_ready = 0;
    check("full_pop_push_ovf", {31'd0, bus.ovf_o}, 32'd0);
    wr(1'b0, 4'd1, 8'h41); wr(1'b0, 4'd1, 8'h42);
    check("overflow_set", {31'd0, bus.ovf_o}, 32'd1);
    drain();

    // Mid-stream reset clears queue and forgets the latched register
    wr(1'b0, 4'd1, 8'h50); wr(1'b0, 4'd1, 8'h51);
    do_reset();
    check("reset_valid", {31'd0, bus.evt_valid}, 32'd0);
    init_side(1'b0);
    wr(1'b0, 4'd1, 8'h55); wr(1'b0, 4'd0, 8'h06);
    check("post_reset_evt", {18'd0, head()}, {18'd0, 1'b0, 1'b1, 4'h0, 8'h00});
    bus.evt_ready = 1; idle(); bus.evt_ready = 0;
    check("no_write_wo_latch", {31'd0, bus.evt_valid}, 32'd0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [3:0] rn;
      logic [7:0] d;
      r = $urandom_range(0, 99);
      bus.evt_ready = ($urandom_range(0, 3) == 0);
      if (r < 8) idle();
      else if (r < 13) cycle(1'b1, {8'hC4, 8'($urandom)}, 8'($urandom), 1'b1);
      else if (r < 18) cycle(1'b1, {($urandom_range(0, 1) != 0) ? 8'hC5 : 8'hC3, 8'($urandom)},
                             8'($urandom), 1'b0);
      else if (r < 19) do_reset();
      else begin
        rn = reg_tab[$urandom_range(0, 9)];
        if (rn == 4'd0) d = orb_tab[$urandom_range(0, 5)];
        else if (rn == 4'd2 || rn == 4'd3) d = ($urandom_range(0, 4) != 0) ? 8'hFF : 8'($urandom);
        else d = 8'($urandom_range(0, 24));
        wr(1'($urandom_range(0, 1)), rn, d);
      end
    end
    bus.evt_ready = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
